// File: rtl/mujika_ctrl_pkg.sv
// Shared top-control definitions: command codes, dispatcher FSM encodings and
// the request encoder helpers used by the dispatcher.
package mujika_ctrl_pkg;

   localparam int CMD_W = 2;
   localparam int EV_W  = 4;

   localparam logic [CMD_W-1:0] CMD_0 = 2'd0;
   localparam logic [CMD_W-1:0] CMD_1 = 2'd1;
   localparam logic [CMD_W-1:0] CMD_2 = 2'd2;
   localparam logic [CMD_W-1:0] CMD_3 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } disp_state_t;

   // The highest set request bit selects the command code.
   function automatic logic [CMD_W-1:0] encode_req(input logic [EV_W-1:0] req);
      logic [CMD_W-1:0] code;
      if (req[3])      code = CMD_3;
      else if (req[2]) code = CMD_2;
      else if (req[1]) code = CMD_1;
      else             code = CMD_0;
      return code;
   endfunction

   function automatic logic multi_req(input logic [EV_W-1:0] req);
      return (req & (req - EV_W'(1))) != '0;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock command FIFO with registered occupancy and flags.
// A write while full is refused even if a read happens in the same cycle.
module cmd_fifo
   import mujika_ctrl_pkg::*;
#(
   parameter int WIDTH = CMD_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk_50,
   input  logic                       sys_rst_n,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [WIDTH-1:0] mem_q [DEPTH];
   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   cnt_t             count_q, count_d;
   logic             full_q, empty_q;
   logic             push_ok, pop_ok;

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   assign push_ok = wr_en_i && !full_q;
   assign pop_ok  = rd_en_i && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (push_ok && !pop_ok)      count_d = count_q + cnt_t'(1);
      else if (!push_ok && pop_ok) count_d = count_q - cnt_t'(1);
   end

   always_ff @(posedge clk_50 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == cnt_t'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   always_ff @(posedge clk_50) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign full_o    = full_q;
   assign empty_o   = empty_q;

endmodule

// File: rtl/cmd_dispatcher.sv
// Queues control events as command codes and issues them one at a time to the
// UDP state sender, with completion timeout, bounded retry and drop accounting.
module cmd_dispatcher
   import mujika_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int MAX_RETRY      = 2
) (
   input  logic                          clk_50,
   input  logic                          sys_rst_n,
   input  logic [EV_W-1:0]               ev_req,
   input  logic                          tx_done,
   output logic [CMD_W-1:0]              cmd_out,
   output logic                          cmd_valid,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   pending,
   output logic [7:0]                    drop_cnt,
   output logic                          timeout_err,
   output disp_state_t                   dbg_state
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   disp_state_t      state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [7:0]       drop_q, drop_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             busy_q, busy_d;
   logic             timeout_err_q, timeout_err_d;

   logic             push_req, multi_hot;
   logic [CMD_W-1:0] push_code, head_code;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
   logic             pop, retry_now, abandon, tmr_expired;

   assign push_req    = |ev_req;
   assign multi_hot   = multi_req(ev_req);
   assign push_code   = encode_req(ev_req);
   assign tmr_expired = (timer_q == TMR_LAST);

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk_50    (clk_50),
      .sys_rst_n (sys_rst_n),
      .wr_en_i   (push_req),
      .wr_data_i (push_code),
      .rd_en_i   (pop),
      .rd_data_o (head_code),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge clk_50 or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Sender handshake: cmd_valid is a one-cycle offer of cmd_out; the sender
   // answers with a one-cycle tx_done, which only counts while in WAIT_DONE.
   // tx_done takes priority over a timer expiry in the same cycle.
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      retry_now = 1'b0;
      abandon   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (tx_done) begin
               state_d = ST_GAP;
            end else if (tmr_expired && (retry_q < RTY_MAX)) begin
               retry_now = 1'b1;
               state_d   = ST_ISSUE;
            end else if (tmr_expired) begin
               abandon = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so they line up with it.
   always_comb begin
      cmd_valid_d   = (state_d == ST_ISSUE);
      busy_d        = (state_d != ST_IDLE);
      timeout_err_d = abandon;
      cmd_d         = pop ? head_code : cmd_q;
      timer_d       = (state_q == ST_WAIT_DONE) ? timer_q + TMR_W'(1) : '0;
      retry_d       = retry_q;
      if (pop)            retry_d = '0;
      else if (retry_now) retry_d = retry_q + RTY_W'(1);
      drop_d = drop_q;
      if ((multi_hot || (push_req && fifo_full)) && (drop_q != 8'hFF))
         drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk_50 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         timer_q       <= '0;
         retry_q       <= '0;
         cmd_q         <= CMD_0;
         drop_q        <= '0;
         cmd_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         timer_q       <= timer_d;
         retry_q       <= retry_d;
         cmd_q         <= cmd_d;
         drop_q        <= drop_d;
         cmd_valid_q   <= cmd_valid_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign cmd_out     = cmd_q;
   assign cmd_valid   = cmd_valid_q;
   assign busy        = busy_q;
   assign pending     = fifo_count;
   assign drop_cnt    = drop_q;
   assign timeout_err = timeout_err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher with a short timeout so retry and abandon
// paths are reachable; all activity happens on the falling clock edge.
module tb_cmd_dispatcher;
   import mujika_ctrl_pkg::*;

   logic        clk_50 = 1'b0;
   logic        sys_rst_n;
   logic [3:0]  ev_req;
   logic        tx_done;
   logic [1:0]  cmd_out;
   logic        cmd_valid;
   logic        busy;
   logic [2:0]  pending;
   logic [7:0]  drop_cnt;
   logic        timeout_err;
   disp_state_t dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   cmd_dispatcher #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16),
      .MAX_RETRY      (2)
   ) dut (
      .clk_50      (clk_50),
      .sys_rst_n   (sys_rst_n),
      .ev_req      (ev_req),
      .tx_done     (tx_done),
      .cmd_out     (cmd_out),
      .cmd_valid   (cmd_valid),
      .busy        (busy),
      .pending     (pending),
      .drop_cnt    (drop_cnt),
      .timeout_err (timeout_err),
      .dbg_state   (dbg_state)
   );

   always #10 clk_50 = ~clk_50;
   always @(posedge clk_50) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One call = move to the next falling edge (the next cycle).
   task automatic step();
      @(negedge clk_50);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      ev_req    = '0;
      tx_done   = 1'b0;
      step();
      sys_rst_n = 1'b1;
      step();
   endtask

   task automatic wait_valid(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (cmd_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      ev_req    = '0;
      tx_done   = 1'b0;
      step();
      step();
      n_checks++;
      if ({cmd_out, cmd_valid, busy, pending, drop_cnt, timeout_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got out=%0d v=%b busy=%b pend=%0d drop=%0d err=%b, expected all zero",
                  cmd_out, cmd_valid, busy, pending, drop_cnt, timeout_err);
      end
      n_checks++;
      if (dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
      end
      sys_rst_n = 1'b1;
      step();
      step();
      n_checks++;
      if ({cmd_valid, busy, pending} !== '0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got v=%b busy=%b pend=%0d expected 0/0/0",
                  cmd_valid, busy, pending);
      end
   endtask

   task automatic test_single();
      do_reset();
      ev_req = 4'b0100;
      step();
      ev_req = '0;
      n_checks++;
      if (pending !== 3'd1 || cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_n1: got pend=%0d v=%b expected pend=1 v=0", pending, cmd_valid);
      end
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_out !== 2'd2) begin
         n_fail++;
         $display("FAIL single_issue: got v=%b out=%0d expected v=1 out=2", cmd_valid, cmd_out);
      end
      n_checks++;
      if (pending !== 3'd0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_n2: got pend=%0d busy=%b expected pend=0 busy=1", pending, busy);
      end
      step();
      n_checks++;
      if (cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pulse_width: got v=%b expected 0", cmd_valid);
      end
      repeat (4) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_gap_busy: got %b expected 1", busy);
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || cmd_out !== 2'd2) begin
         n_fail++;
         $display("FAIL single_done: got busy=%b out=%0d expected busy=0 out=2", busy, cmd_out);
      end
   endtask

   task automatic test_multi();
      do_reset();
      ev_req = 4'b1011;
      step();
      ev_req = '0;
      n_checks++;
      if (drop_cnt !== 8'd1 || pending !== 3'd1) begin
         n_fail++;
         $display("FAIL multi_drop: got drop=%0d pend=%0d expected drop=1 pend=1", drop_cnt, pending);
      end
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_out !== 2'd3) begin
         n_fail++;
         $display("FAIL multi_issue: got v=%b out=%0d expected v=1 out=3", cmd_valid, cmd_out);
      end
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      n_checks++;
      if (busy !== 1'b0 || drop_cnt !== 8'd1 || pending !== 3'd0) begin
         n_fail++;
         $display("FAIL multi_end: got busy=%b drop=%0d pend=%0d expected 0/1/0", busy, drop_cnt, pending);
      end
   endtask

   // Overflow fill, then in-order drain with back-to-back completions.
   task automatic test_overflow();
      int         codes[6];
      logic [1:0] exp_q[$];
      logic [1:0] got_q[$];
      logic [1:0] e;
      int         last_v;
      bit         ok;
      codes  = '{0, 1, 2, 3, 0, 1};
      exp_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      last_v = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         ev_req = 4'(1 << codes[i]);
         step();
         if (cmd_valid === 1'b1) begin
            got_q.push_back(cmd_out);
            last_v = cyc;
         end
      end
      ev_req = '0;
      n_checks++;
      if (pending !== 3'd4 || drop_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL ovf_fill: got pend=%0d drop=%0d expected pend=4 drop=1", pending, drop_cnt);
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_valid(12, ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL ovf_issue_timeout: issue %0d not seen within 12 cycles", k + 1);
         end else begin
            if (k > 0) begin
               n_checks++;
               if (cyc - last_v != 4) begin
                  n_fail++;
                  $display("FAIL b2b_spacing: got %0d cycles expected 4", cyc - last_v);
               end
            end
            got_q.push_back(cmd_out);
            last_v = cyc;
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
         end
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL ovf_count: got %0d issues expected %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[i] !== e) begin
               n_fail++;
               $display("FAIL ovf_order[%0d]: got %0d expected %0d", i, got_q[i], e);
            end
         end
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || pending !== 3'd0 || drop_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL ovf_end: got busy=%b pend=%0d drop=%0d expected 0/0/1", busy, pending, drop_cnt);
      end
   endtask

   task automatic test_timeout();
      int         v_cyc[$];
      logic [1:0] v_code[$];
      int         e_cyc[$];
      int         exp_v[4];
      logic [1:0] exp_c[4];
      int         t0;
      exp_v = '{0, 17, 34, 53};
      exp_c = '{2'd1, 2'd1, 2'd1, 2'd2};
      do_reset();
      ev_req = 4'b0010;
      step();
      ev_req = 4'b0100;
      step();
      ev_req = '0;
      t0 = cyc;
      for (int i = 0; i < 60; i++) begin
         if (cmd_valid === 1'b1) begin
            v_cyc.push_back(cyc - t0);
            v_code.push_back(cmd_out);
         end
         if (timeout_err === 1'b1) e_cyc.push_back(cyc - t0);
         step();
      end
      n_checks++;
      if (v_cyc.size() != 4) begin
         n_fail++;
         $display("FAIL tmo_pulses: got %0d cmd_valid pulses expected 4", v_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (v_cyc[i] != exp_v[i] || v_code[i] !== exp_c[i]) begin
               n_fail++;
               $display("FAIL tmo_pulse[%0d]: got cycle +%0d code %0d expected +%0d code %0d",
                        i, v_cyc[i], v_code[i], exp_v[i], exp_c[i]);
            end
         end
      end
      n_checks++;
      if (e_cyc.size() != 1) begin
         n_fail++;
         $display("FAIL tmo_err_count: got %0d timeout_err cycles expected 1", e_cyc.size());
      end else begin
         n_checks++;
         if (e_cyc[0] != 51) begin
            n_fail++;
            $display("FAIL tmo_err_cycle: got +%0d expected +51", e_cyc[0]);
         end
      end
   endtask

   task automatic test_race();
      int n_v;
      int n_e;
      n_v = 0;
      n_e = 0;
      do_reset();
      ev_req = 4'b1000;
      step();
      ev_req = '0;
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_out !== 2'd3) begin
         n_fail++;
         $display("FAIL race_issue: got v=%b out=%0d expected v=1 out=3", cmd_valid, cmd_out);
      end
      repeat (16) step();
      n_checks++;
      if (dbg_state !== ST_WAIT_DONE) begin
         n_fail++;
         $display("FAIL race_state: got %0d expected WAIT_DONE(%0d)", dbg_state, ST_WAIT_DONE);
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      n_checks++;
      if (dbg_state !== ST_GAP || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL race_gap: got state=%0d busy=%b expected GAP(%0d) busy=1", dbg_state, busy, ST_GAP);
      end
      for (int i = 0; i < 20; i++) begin
         if (cmd_valid === 1'b1) n_v++;
         if (timeout_err === 1'b1) n_e++;
         step();
      end
      n_checks++;
      if (n_v != 0 || n_e != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL race_quiet: got %0d reissues %0d errors busy=%b expected 0/0/0", n_v, n_e, busy);
      end
   endtask

   task automatic test_reset_mid();
      int n_v;
      n_v = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ev_req = 4'(1 << i);
         step();
      end
      ev_req = '0;
      n_checks++;
      if (pending !== 3'd3 || dbg_state !== ST_WAIT_DONE) begin
         n_fail++;
         $display("FAIL rstmid_pre: got pend=%0d state=%0d expected pend=3 state=%0d",
                  pending, dbg_state, ST_WAIT_DONE);
      end
      #3 sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cmd_out, cmd_valid, busy, pending, drop_cnt, timeout_err} !== '0 || dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL rstmid_async: got out=%0d v=%b busy=%b pend=%0d err=%b state=%0d expected all zero",
                  cmd_out, cmd_valid, busy, pending, timeout_err, dbg_state);
      end
      step();
      step();
      sys_rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (cmd_valid === 1'b1 || timeout_err === 1'b1) n_v++;
         step();
      end
      n_checks++;
      if (n_v != 0 || pending !== 3'd0) begin
         n_fail++;
         $display("FAIL rstmid_quiet: got %0d pulses pend=%0d expected 0/0", n_v, pending);
      end
      ev_req = 4'b0001;
      step();
      ev_req = '0;
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_out !== 2'd0) begin
         n_fail++;
         $display("FAIL rstmid_new: got v=%b out=%0d expected v=1 out=0", cmd_valid, cmd_out);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      ev_req = 4'b0011;
      repeat (260) step();
      ev_req = '0;
      n_checks++;
      if (drop_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_value: got %0d expected 255", drop_cnt);
      end
      step();
      n_checks++;
      if (drop_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_hold: got %0d expected 255", drop_cnt);
      end
   endtask

   initial begin
      sys_rst_n = 1'b0;
      ev_req    = '0;
      tx_done   = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_overflow();
      test_timeout();
      test_race();
      test_reset_mid();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
